alu_result_tx: RTL and testbench
================================

ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 Parameter NB_DATA, default 8, width of ALU result and of each serial data word (SHALL be >= 2).
REQ-002 Parameter CLKS_PER_BIT, default 10417, clock cycles per serial bit (100 MHz / 9600 baud; SHALL be >= 2).
REQ-003 I_clk  input  1  single clock; all state updates on rising edge.
REQ-004 I_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 I_send  input  1  request to capture and transmit current ALU outputs; sampled each cycle.
REQ-006 I_result  input  NB_DATA  ALU result to transmit.
REQ-007 I_overflow  input  1  ALU overflow flag.
REQ-008 I_zero  input  1  ALU zero flag.
REQ-009 O_tx  output  1  serial line, idle high, registered.
REQ-010 O_busy  output  1  high while a transfer is in progress, registered.
REQ-011 O_done  output  1  one-cycle pulse on transfer completion, registered.

Function
REQ-012 A transfer SHALL send two back-to-back frames: word0 = captured result; word1 = {zeros, overflow, zero} (zero at bit 0, overflow at bit 1, upper bits 0).
REQ-013 Each frame SHALL be: start bit 0, NB_DATA data bits LSB first, optional parity bit (REQ-027), stop bit 1; every bit SHALL hold O_tx for exactly CLKS_PER_BIT cycles.
REQ-014 FSM states: IDLE, START, DATA, PARITY (present only with macro), STOP; after STOP of word0 go to START of word1; after STOP of word1 go to IDLE.
REQ-015 In IDLE, I_send high at edge k SHALL capture I_result, I_overflow, I_zero into internal registers at edge k, and O_tx=0, O_busy=1 from cycle k+1.
REQ-016 Inputs changing after capture SHALL NOT affect the transfer in progress.
REQ-017 I_send while O_busy=1 SHALL be ignored (not queued).
REQ-018 Bit timing SHALL use an internal down-counter reloaded to CLKS_PER_BIT-1 at each bit start; bit index counter 0..NB_DATA-1; word index 0..1.
REQ-019 No idle gap between word0 stop bit and word1 start bit.
REQ-020 Transfer length SHALL be 2*(NB_DATA+2)*CLKS_PER_BIT cycles of O_busy=1 (2*(NB_DATA+3)*CLKS_PER_BIT with parity).
REQ-021 On completion of word1 stop bit, O_busy SHALL fall and O_done SHALL pulse high for exactly one cycle, same cycle; O_tx stays 1.
REQ-022 I_send high in the same cycle O_done is high SHALL be accepted (FSM is in IDLE that cycle), starting a new transfer next cycle.
REQ-023 O_tx SHALL be 1 whenever in IDLE.

Reset
REQ-024 I_reset_n low SHALL immediately force O_tx=1, O_busy=0, O_done=0, FSM=IDLE, all counters and captured registers to 0, independent of I_clk.
REQ-025 Reset asserted mid-frame SHALL abort the transfer with no O_done pulse; after release the block SHALL idle until a new I_send.
REQ-026 Release of reset SHALL take effect on the first rising edge of I_clk after I_reset_n goes high.

Configuration
REQ-027 Macro ALU_RESULT_TX_PARITY_EN: when defined, an even-parity bit (XOR of the NB_DATA data bits) SHALL be inserted between last data bit and stop bit of each frame; when undefined, the PARITY state and logic SHALL be absent and frames SHALL be NB_DATA+2 bits.

Verification (NB_DATA=8, CLKS_PER_BIT=4)
REQ-028 Send result=0x5A, ovf=0, zero=0, no macro -> O_tx: 0,0,1,0,1,1,0,1,0,1 then 0,0x00 bits,1, each bit 4 cycles; O_busy high 80 cycles; single O_done pulse.
REQ-029 Send result=0x00, zero=1, ovf=0 -> word0 = 0x00, word1 = 0x01 on the line.
REQ-030 Macro defined, send result=0x07, ovf=1, zero=0 -> word0 parity bit 1, word1 = 0x02 with parity bit 1; O_busy high 88 cycles.
REQ-031 Pulse I_send again at cycle 10 of a transfer and change I_result -> ignored; line content and 80-cycle length unchanged.
REQ-032 Assert I_reset_n low at cycle 30 of a transfer -> O_tx=1, O_busy=0 immediately, no O_done; next I_send transmits normally.
REQ-033 Hold I_send high continuously with result=0xFF -> transfers repeat with exactly one idle cycle (O_done cycle) between them.

Source files
------------

// File: rtl/alu_result_tx_if.sv
// alu_result_tx_if: capture request, ALU outputs and serial status signals
// exchanged between an ALU-side driver and the alu_result_tx serializer.
interface alu_result_tx_if #(
  parameter int NB_DATA = 8
);
  logic               send;
  logic [NB_DATA-1:0] result;
  logic               overflow;
  logic               zero;
  logic               tx;
  logic               busy;
  logic               done;

  modport master (
    output send, result, overflow, zero,
    input  tx, busy, done
  );

  modport slave (
    input  send, result, overflow, zero,
    output tx, busy, done
  );
endinterface

// File: rtl/alu_result_tx.sv
// alu_result_tx: captures an ALU result plus its overflow/zero flags and
// sends them as two back-to-back UART-style frames (result word, then a flag
// word with zero at bit 0 and overflow at bit 1).
// Optional feature: define ALU_RESULT_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit of every frame.
module alu_result_tx #(
  parameter int NB_DATA      = 8,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic           I_clk,
  input  logic           I_reset_n,
  alu_result_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NB_DATA);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);

`ifdef ALU_RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               word_q, word_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture;
  logic [NB_DATA-1:0] res_q;
  logic               ovf_q;
  logic               zero_q;
  logic [NB_DATA-1:0] flag_word;
  logic [NB_DATA-1:0] cur_word;

  // Select the word being serialized: captured result first, then the flags.
  always_comb begin
    flag_word    = '0;
    flag_word[0] = zero_q;
    flag_word[1] = ovf_q;
    cur_word     = word_q ? flag_word : res_q;
  end

  // Next-state logic; tx/busy/done are computed one cycle ahead so that the
  // registered outputs line up with the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.send) begin
          capture = 1'b1;
          state_d = START;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          word_d  = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          tx_d    = cur_word[0];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == BIT_LAST) begin
`ifdef ALU_RESULT_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^cur_word;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
            tx_d  = cur_word[bit_q + BIT_ONE];
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = CNT_RELOAD;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          if (!word_q) begin
            state_d = START;
            cnt_d   = CNT_RELOAD;
            word_d  = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            word_d  = 1'b0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        word_d  = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered line outputs.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot of the ALU outputs, taken only when a transfer is accepted.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      res_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (capture) begin
      res_q  <= bus.result;
      ovf_q  <= bus.overflow;
      zero_q <= bus.zero;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: directed bench for alu_result_tx with NB_DATA=8 and
// CLKS_PER_BIT=4. Expected line waveforms are built from hand-specified
// words; honours ALU_RESULT_TX_PARITY_EN when defined.
module tb_alu_result_tx;

  localparam int NB  = 8;
  localparam int CPB = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int FRAME_BITS = NB + 3;
`else
  localparam int FRAME_BITS = NB + 2;
`endif
  localparam int TOTAL = 2 * FRAME_BITS * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;
  logic expLine [TOTAL];

  alu_result_tx_if #(.NB_DATA(NB)) bus ();

  alu_result_tx #(
    .NB_DATA     (NB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .I_clk    (clk),
    .I_reset_n(rst_n),
    .bus      (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected per-cycle line value for one two-frame transfer.
  task automatic buildExpected(input logic [NB-1:0] res, input logic ovf,
                               input logic zr);
    logic [NB-1:0] w [2];
    logic          frame [FRAME_BITS];
    int            pos;
    w[0]    = res;
    w[1]    = '0;
    w[1][0] = zr;
    w[1][1] = ovf;
    pos     = 0;
    for (int wi = 0; wi < 2; wi++) begin
      frame[0] = 1'b0;
      for (int b = 0; b < NB; b++) frame[b + 1] = w[wi][b];
`ifdef ALU_RESULT_TX_PARITY_EN
      frame[NB + 1] = ^w[wi];
`endif
      frame[FRAME_BITS - 1] = 1'b1;
      for (int f = 0; f < FRAME_BITS; f++) begin
        for (int c = 0; c < CPB; c++) begin
          expLine[pos] = frame[f];
          pos++;
        end
      end
    end
  endtask

  // Run one transfer from an idle negedge up to its done cycle. pokeAt >= 0
  // re-pulses send with altered inputs mid-transfer; holdSend keeps send high.
  task automatic applyStimulus(input logic [NB-1:0] res, input logic ovf,
                               input logic zr, input int pokeAt,
                               input bit holdSend, input string tag);
    buildExpected(res, ovf, zr);
    bus.result   = res;
    bus.overflow = ovf;
    bus.zero     = zr;
    bus.send     = 1'b1;
    @(negedge clk);
    if (!holdSend) bus.send = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      checkOutput($sformatf("%s tx c%0d", tag, i), {31'd0, bus.tx}, {31'd0, expLine[i]});
      checkOutput($sformatf("%s busy/done c%0d", tag, i),
                  {30'd0, bus.busy, bus.done}, 32'd2);
      if (i == pokeAt) begin
        bus.send     = 1'b1;
        bus.result   = ~res;
        bus.overflow = ~ovf;
        bus.zero     = ~zr;
      end else if (i == pokeAt + 1 && !holdSend) begin
        bus.send = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s done cycle tx/busy/done", tag),
                {29'd0, bus.tx, bus.busy, bus.done}, 32'd5);
  endtask

  initial begin
    bus.send     = 1'b0;
    bus.result   = '0;
    bus.overflow = 1'b0;
    bus.zero     = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    @(negedge clk);
    checkOutput("reset held", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle after reset", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    end

    // Basic transfers with different result/flag patterns.
    applyStimulus(8'h5A, 1'b0, 1'b0, -1, 1'b0, "r5A");
    @(negedge clk);
    checkOutput("r5A done one cycle", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    applyStimulus(8'h00, 1'b0, 1'b1, -1, 1'b0, "r00z");
    @(negedge clk);
    applyStimulus(8'h07, 1'b1, 1'b0, -1, 1'b0, "r07o");
    @(negedge clk);

    // Send re-pulsed with new inputs mid-transfer must be ignored.
    applyStimulus(8'h3C, 1'b0, 1'b1, 10, 1'b0, "poke");
    @(negedge clk);
    checkOutput("poke not queued", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);

    // Reset in the middle of a frame aborts without a done pulse.
    buildExpected(8'hA5, 1'b1, 1'b1);
    bus.result   = 8'hA5;
    bus.overflow = 1'b1;
    bus.zero     = 1'b1;
    bus.send     = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checkOutput($sformatf("abort tx c%0d", i), {31'd0, bus.tx}, {31'd0, expLine[i]});
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1 checkOutput("abort async", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort idle c%0d", i),
                  {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
    end
    applyStimulus(8'h81, 1'b1, 1'b0, -1, 1'b0, "after abort");
    @(negedge clk);

    // Send held high: back-to-back transfers separated only by the done cycle.
    applyStimulus(8'hFF, 1'b0, 1'b0, -1, 1'b1, "hold1");
    applyStimulus(8'hFF, 1'b0, 1'b0, -1, 1'b0, "hold2");
    @(negedge clk);
    checkOutput("hold end idle", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
